// File: rtl/upg_loader_fsm_if.sv
// Upgrade-loader bus: UART byte stream and mode enable in, memory write port and status out.
// The master side is the byte source / host; the slave side is the loader FSM.
interface upg_loader_fsm_if #(
    parameter int unsigned IDX_W = 14
);
    logic             en_i;
    logic [7:0]       rx_data_i;
    logic             rx_valid_i;
    logic             upg_wen_o;
    logic [IDX_W:0]   upg_adr_o;
    logic [31:0]      upg_dat_o;
    logic             upg_done_o;
    logic             err_o;
    logic             busy_o;

    modport master (
        output en_i, rx_data_i, rx_valid_i,
        input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o
    );

    modport slave (
        input  en_i, rx_data_i, rx_valid_i,
        output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o
    );
endinterface

// File: rtl/upg_loader_fsm.sv
// Framed byte-stream loader for IMem/DMem: TARGET, CNT_LO, CNT_HI, then CNT little-endian words.
// Issues one-cycle write strobes, flags bad targets and inter-byte timeouts, and latches a done flag.
module upg_loader_fsm #(
    parameter logic [22:0] TIMEOUT_CYCLES = 23'd5_000_000,
    parameter int unsigned IDX_W          = 14
) (
    input logic             clk,
    input logic             rst,
    upg_loader_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             tgt_r;
    logic [7:0]       cnt_lo_r;
    logic [15:0]      remain_r;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       lane_r;
    logic [23:0]      word_r;
    logic [22:0]      tmo_r;
    logic             wen_r;
    logic [IDX_W:0]   adr_r;
    logic [31:0]      dat_r;
    logic             done_r;
    logic             err_r;
    logic             busy_r;

    logic             in_frame_s;
    logic             tmo_hit_s;

    // Frame-phase decode and inter-byte timeout detection
    always_comb begin
        in_frame_s = 1'b0;
        tmo_hit_s  = 1'b0;
        if ((state_r == ST_HDR_LO) || (state_r == ST_HDR_HI) || (state_r == ST_DATA)) begin
            in_frame_s = 1'b1;
        end else begin
            in_frame_s = 1'b0;
        end
        if (in_frame_s && !bus.rx_valid_i && ((tmo_r + 23'd1) >= TIMEOUT_CYCLES)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Loader state machine with registered write port and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            tgt_r    <= 1'b0;
            cnt_lo_r <= 8'd0;
            remain_r <= 16'd0;
            idx_r    <= '0;
            lane_r   <= 2'd0;
            word_r   <= 24'd0;
            tmo_r    <= 23'd0;
            wen_r    <= 1'b0;
            adr_r    <= '0;
            dat_r    <= 32'd0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else if (!bus.en_i) begin
            // Leaving upgrade mode: start fresh next time, but keep the last address/data visible
            state_r  <= ST_IDLE;
            remain_r <= 16'd0;
            idx_r    <= '0;
            lane_r   <= 2'd0;
            tmo_r    <= 23'd0;
            wen_r    <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            wen_r <= 1'b0;
            if (in_frame_s && !bus.rx_valid_i) begin
                tmo_r <= tmo_r + 23'd1;
            end else begin
                tmo_r <= 23'd0;
            end

            if (tmo_hit_s) begin
                // Abandon the frame; a partially assembled word is never written
                state_r <= ST_IDLE;
                err_r   <= 1'b1;
                busy_r  <= 1'b0;
                lane_r  <= 2'd0;
                tmo_r   <= 23'd0;
            end else if (bus.rx_valid_i) begin
                case (state_r)
                    ST_IDLE: begin
                        case (bus.rx_data_i)
                            8'h00, 8'h01: begin
                                tgt_r   <= bus.rx_data_i[0];
                                state_r <= ST_HDR_LO;
                                busy_r  <= 1'b1;
                            end
                            8'hFF: begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b1;
                            end
                            default: begin
                                err_r <= 1'b1;
                            end
                        endcase
                    end
                    ST_HDR_LO: begin
                        cnt_lo_r <= bus.rx_data_i;
                        state_r  <= ST_HDR_HI;
                    end
                    ST_HDR_HI: begin
                        if ({bus.rx_data_i, cnt_lo_r} == 16'd0) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            remain_r <= {bus.rx_data_i, cnt_lo_r};
                            idx_r    <= '0;
                            lane_r   <= 2'd0;
                            state_r  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        lane_r <= lane_r + 2'd1;
                        case (lane_r)
                            2'd0: word_r[7:0]   <= bus.rx_data_i;
                            2'd1: word_r[15:8]  <= bus.rx_data_i;
                            2'd2: word_r[23:16] <= bus.rx_data_i;
                            2'd3: begin
                                // Index wraps silently past the end of the memory
                                dat_r    <= {bus.rx_data_i, word_r};
                                adr_r    <= {tgt_r, idx_r};
                                wen_r    <= 1'b1;
                                idx_r    <= idx_r + IDX_ONE;
                                remain_r <= remain_r - 16'd1;
                                if (remain_r == 16'd1) begin
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end else begin
                                    state_r <= ST_DATA;
                                end
                            end
                            default: lane_r <= 2'd0;
                        endcase
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.upg_wen_o  = wen_r;
    assign bus.upg_adr_o  = adr_r;
    assign bus.upg_dat_o  = dat_r;
    assign bus.upg_done_o = done_r;
    assign bus.err_o      = err_r;
    assign bus.busy_o     = busy_r;

endmodule

// File: tb/tb_upg_loader_fsm.sv
// Self-checking bench for upg_loader_fsm: scenario tasks compare observed writes and status
// against a word-level frame model (expected writes computed from target, count and words).
module tb_upg_loader_fsm;

    logic clk = 1'b0;
    logic rst;

    upg_loader_fsm_if bus ();

    upg_loader_fsm #(.TIMEOUT_CYCLES(23'd100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [46:0] obs [0:32767];
    int          obs_n = 0;
    int          rd_p  = 0;
    logic [46:0] exp_q [$];
    logic [31:0] words_q [$];
    logic [46:0] exp_w;

    // Record every write strobe seen on the memory port
    always @(negedge clk) begin
        if (!rst && bus.upg_wen_o && obs_n < 32768) begin
            obs[obs_n] = {bus.upg_adr_o, bus.upg_dat_o};
            obs_n = obs_n + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame from words_q; expected writes follow the frame rules (index modulo 2^14)
    task automatic send_frame(input logic [7:0] tgt, input int cnt, input int gap_max, input bit expect_w);
        logic [15:0] c;
        logic [31:0] w;
        c = 16'(cnt);
        send_byte(tgt);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
        for (int k = 0; k < cnt; k++) begin
            w = words_q.pop_front();
            if (expect_w) exp_q.push_back({tgt[0], 14'(k % 16384), w});
            for (int b = 0; b < 4; b++) begin
                send_byte(w[8*b +: 8]);
                if (gap_max > 0) idle(int'($urandom_range(32'(gap_max), 32'd0)));
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.en_i = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(1);
        n_cmp++; if (bus.upg_wen_o !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", bus.upg_wen_o); end
        n_cmp++; if (bus.upg_adr_o !== 15'h0) begin n_err++; $display("FAIL reset_adr got %h want 0000", bus.upg_adr_o); end
        n_cmp++; if (bus.upg_dat_o !== 32'h0) begin n_err++; $display("FAIL reset_dat got %h want 0", bus.upg_dat_o); end
        n_cmp++; if (bus.upg_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.upg_done_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus.err_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    endtask

    task automatic test_basic;
        bus.en_i = 1'b1;
        idle(1);
        words_q.push_back(32'h12345678);
        words_q.push_back(32'hDEADBEEF);
        send_frame(8'h00, 2, 0, 1'b1);
        idle(2);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.upg_adr_o !== 15'h0001) begin n_err++; $display("FAIL basic_adr_hold got %h want 0001", bus.upg_adr_o); end
        n_cmp++; if (bus.upg_dat_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_dat_hold got %h want deadbeef", bus.upg_dat_o); end
        n_cmp++;
        if (obs_n - rd_p !== exp_q.size()) begin n_err++; $display("FAIL basic_wr_count got %0d want %0d", obs_n - rd_p, exp_q.size()); end
        while (rd_p < obs_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front(); n_cmp++;
            if (obs[rd_p] !== exp_w) begin n_err++; $display("FAIL basic_wr got %h/%h want %h/%h", obs[rd_p][46:32], obs[rd_p][31:0], exp_w[46:32], exp_w[31:0]); end
            rd_p++;
        end
        rd_p = obs_n; exp_q.delete();
    endtask

    task automatic test_dmem_done;
        words_q.push_back(32'h11223344);
        send_frame(8'h01, 1, 0, 1'b1);
        send_byte(8'hFF);
        n_cmp++; if (bus.upg_done_o !== 1'b1) begin n_err++; $display("FAIL done_set got %b want 1", bus.upg_done_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL done_busy got %b want 1", bus.busy_o); end
        words_q.push_back(32'hCAFEF00D);
        send_frame(8'h00, 1, 1, 1'b0);
        idle(3);
        n_cmp++; if (bus.upg_done_o !== 1'b1) begin n_err++; $display("FAIL done_sticky got %b want 1", bus.upg_done_o); end
        n_cmp++;
        if (obs_n - rd_p !== exp_q.size()) begin n_err++; $display("FAIL dmem_wr_count got %0d want %0d", obs_n - rd_p, exp_q.size()); end
        while (rd_p < obs_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front(); n_cmp++;
            if (obs[rd_p] !== exp_w) begin n_err++; $display("FAIL dmem_wr got %h/%h want %h/%h", obs[rd_p][46:32], obs[rd_p][31:0], exp_w[46:32], exp_w[31:0]); end
            rd_p++;
        end
        rd_p = obs_n; exp_q.delete();
    endtask

    task automatic test_en_drop;
        bus.en_i = 1'b0;
        idle(1);
        n_cmp++; if (bus.upg_done_o !== 1'b0) begin n_err++; $display("FAIL endrop_done got %b want 0", bus.upg_done_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL endrop_busy got %b want 0", bus.busy_o); end
        send_byte(8'h00);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL endrop_ignore got %b want 0", bus.busy_o); end
        bus.en_i = 1'b1;
        idle(1);
    endtask

    task automatic test_zero_and_err;
        send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL zero_busy_mid got %b want 1", bus.busy_o); end
        send_byte(8'h00);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL zero_busy_end got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL zero_err got %b want 0", bus.err_o); end
        send_byte(8'h7A);
        n_cmp++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL badtgt_err got %b want 1", bus.err_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL badtgt_busy got %b want 0", bus.busy_o); end
        idle(2);
        n_cmp++; if (obs_n !== rd_p) begin n_err++; $display("FAIL zero_wr_count got %0d want 0", obs_n - rd_p); end
        rd_p = obs_n;
        bus.en_i = 1'b0; idle(1); bus.en_i = 1'b1; idle(1);
    endtask

    task automatic test_timeout;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        idle(99);
        n_cmp++; if (bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) begin n_err++; $display("FAIL tmo_early busy/err got %b/%b want 1/0", bus.busy_o, bus.err_o); end
        idle(1);
        n_cmp++; if (bus.err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err got %b want 1", bus.err_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL tmo_busy got %b want 0", bus.busy_o); end
        words_q.push_back(32'h04030201);
        send_frame(8'h00, 1, 0, 1'b1);
        idle(2);
        n_cmp++;
        if (obs_n - rd_p !== exp_q.size()) begin n_err++; $display("FAIL tmo_wr_count got %0d want %0d", obs_n - rd_p, exp_q.size()); end
        while (rd_p < obs_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front(); n_cmp++;
            if (obs[rd_p] !== exp_w) begin n_err++; $display("FAIL tmo_wr got %h/%h want %h/%h", obs[rd_p][46:32], obs[rd_p][31:0], exp_w[46:32], exp_w[31:0]); end
            rd_p++;
        end
        rd_p = obs_n; exp_q.delete();
        bus.en_i = 1'b0; idle(1); bus.en_i = 1'b1; idle(1);
    endtask

    task automatic test_back_to_back;
        int cnt;
        for (int f = 0; f < 8; f++) begin
            cnt = int'($urandom_range(32'd4, 32'd1));
            for (int k = 0; k < cnt; k++) words_q.push_back($urandom);
            send_frame(8'($urandom_range(32'd1, 32'd0)), cnt, (f < 4) ? 0 : 3, 1'b1);
        end
        idle(2);
        n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL b2b_err got %b want 0", bus.err_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b want 0", bus.busy_o); end
        n_cmp++;
        if (obs_n - rd_p !== exp_q.size()) begin n_err++; $display("FAIL b2b_wr_count got %0d want %0d", obs_n - rd_p, exp_q.size()); end
        while (rd_p < obs_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front(); n_cmp++;
            if (obs[rd_p] !== exp_w) begin n_err++; $display("FAIL b2b_wr got %h/%h want %h/%h", obs[rd_p][46:32], obs[rd_p][31:0], exp_w[46:32], exp_w[31:0]); end
            rd_p++;
        end
        rd_p = obs_n; exp_q.delete();
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 16385; k++) words_q.push_back($urandom);
        send_frame(8'h00, 16385, 0, 1'b1);
        idle(2);
        n_cmp++; if (bus.err_o !== 1'b0) begin n_err++; $display("FAIL wrap_err got %b want 0", bus.err_o); end
        n_cmp++; if (bus.upg_adr_o !== 15'h0000) begin n_err++; $display("FAIL wrap_last_adr got %h want 0000", bus.upg_adr_o); end
        n_cmp++;
        if (obs_n - rd_p !== exp_q.size()) begin n_err++; $display("FAIL wrap_wr_count got %0d want %0d", obs_n - rd_p, exp_q.size()); end
        while (rd_p < obs_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front(); n_cmp++;
            if (obs[rd_p] !== exp_w) begin n_err++; $display("FAIL wrap_wr got %h/%h want %h/%h", obs[rd_p][46:32], obs[rd_p][31:0], exp_w[46:32], exp_w[31:0]); end
            rd_p++;
        end
        rd_p = obs_n; exp_q.delete();
    endtask

    task automatic test_rst_mid;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h8B);
        exp_q.push_back({1'b1, 14'd0, 32'h8BADF00D});
        send_byte(8'h55);
        idle(1);
        rst = 1'b1;
        #2;
        n_cmp++; if (bus.upg_adr_o !== 15'h0 || bus.upg_dat_o !== 32'h0) begin n_err++; $display("FAIL rstmid_adr_dat got %h/%h want 0000/0", bus.upg_adr_o, bus.upg_dat_o); end
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.upg_wen_o !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_wen got %b/%b want 0/0", bus.busy_o, bus.upg_wen_o); end
        n_cmp++; if (bus.upg_done_o !== 1'b0 || bus.err_o !== 1'b0) begin n_err++; $display("FAIL rstmid_done_err got %b/%b want 0/0", bus.upg_done_o, bus.err_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h66);
        idle(2);
        n_cmp++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid_fresh err/busy got %b/%b want 1/0", bus.err_o, bus.busy_o); end
        n_cmp++;
        if (obs_n - rd_p !== exp_q.size()) begin n_err++; $display("FAIL rstmid_wr_count got %0d want %0d", obs_n - rd_p, exp_q.size()); end
        while (rd_p < obs_n && exp_q.size() > 0) begin
            exp_w = exp_q.pop_front(); n_cmp++;
            if (obs[rd_p] !== exp_w) begin n_err++; $display("FAIL rstmid_wr got %h/%h want %h/%h", obs[rd_p][46:32], obs[rd_p][31:0], exp_w[46:32], exp_w[31:0]); end
            rd_p++;
        end
        rd_p = obs_n; exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dmem_done();
        test_en_drop();
        test_zero_and_err();
        test_timeout();
        test_back_to_back();
        test_wrap();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
